// File: rtl/pac_pkg.sv
// Shared Pac-Man movement types: directions, keyboard codes and FSM state encoding.
// Imported by key_decode, key_dir_buffer and the downstream movement stage.
package pac_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_W    = 8'h1A;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MOVE = 1'b1;

endpackage

// File: rtl/key_decode.sv
// Keyboard code <-> direction translation, shared with the movement stage.
// Unrecognised codes decode as no key.
module key_decode
  import pac_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       key_valid,
  output dir_t       key_dir,
  input  dir_t       dir_in,
  output logic [7:0] dir_keycode
);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_valid = 1'b1;
    key_dir   = DIR_LEFT;
    case (keycode)
      KEY_A:   key_dir = DIR_LEFT;
      KEY_D:   key_dir = DIR_RIGHT;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_W:   key_dir = DIR_UP;
      default: key_valid = 1'b0;
    endcase
  end

  always_comb begin
    dir_keycode = KEY_A;
    case (dir_in)
      DIR_LEFT:  dir_keycode = KEY_A;
      DIR_RIGHT: dir_keycode = KEY_D;
      DIR_DOWN:  dir_keycode = KEY_S;
      DIR_UP:    dir_keycode = KEY_W;
      default:   dir_keycode = KEY_A;
    endcase
  end

endmodule

// File: rtl/key_dir_buffer.sv
// Direction buffer: holds the current direction and one pending turn until the path opens.
// Define KEYBUF_TIMEOUT_EN to discard a pending turn after BUF_TIMEOUT frames.
module key_dir_buffer
  import pac_pkg::*;
#(
  parameter int BUF_TIMEOUT = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       leftwall,
  input  logic       rightwall,
  input  logic       downwall,
  input  logic       upwall,
  input  logic       playon,
  output logic [7:0] keycode_out,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       pend_valid,
  output logic [1:0] pend_dir
);

  if (BUF_TIMEOUT < 1 || BUF_TIMEOUT > 31) begin : g_bad_timeout
    $error("key_dir_buffer: BUF_TIMEOUT must be in 1..31");
  end

  state_t     state_q, state_d;
  dir_t       cur_dir_q, cur_dir_d;
  logic       pend_valid_q, pend_valid_d;
  dir_t       pend_dir_q, pend_dir_d;
  logic [7:0] prev_key_q, prev_key_d;

`ifdef KEYBUF_TIMEOUT_EN
  localparam int             AGE_W    = $clog2(BUF_TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_INIT = AGE_W'(BUF_TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

  logic [AGE_W-1:0] age_q, age_d;
`endif

  logic       key_valid;
  dir_t       key_dir;
  logic [7:0] cur_keycode;
  logic       new_key;
  logic [3:0] open_dirs;

  key_decode u_key_decode (
    .keycode     (keycode),
    .key_valid   (key_valid),
    .key_dir     (key_dir),
    .dir_in      (cur_dir_q),
    .dir_keycode (cur_keycode)
  );

  // Indexed by dir_t so a direction selects its own wall flag.
  assign open_dirs = {upwall, downwall, rightwall, leftwall};
  assign new_key   = key_valid && (keycode != prev_key_q);

  always_comb begin
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    prev_key_d   = keycode;
`ifdef KEYBUF_TIMEOUT_EN
    age_d        = age_q;
`endif

    if (!playon) begin
      state_d      = ST_IDLE;
      cur_dir_d    = DIR_LEFT;
      pend_valid_d = 1'b0;
      pend_dir_d   = DIR_LEFT;
      prev_key_d   = KEY_NONE;
`ifdef KEYBUF_TIMEOUT_EN
      age_d        = '0;
`endif
    end else if (new_key) begin
      // Re-pressing the direction already being travelled leaves everything as is.
      if (!(state_q == ST_MOVE && key_dir == cur_dir_q)) begin
        if (open_dirs[key_dir]) begin
          state_d      = ST_MOVE;
          cur_dir_d    = key_dir;
          pend_valid_d = 1'b0;
          pend_dir_d   = DIR_LEFT;
`ifdef KEYBUF_TIMEOUT_EN
          age_d        = '0;
`endif
        end else begin
          pend_valid_d = 1'b1;
          pend_dir_d   = key_dir;
`ifdef KEYBUF_TIMEOUT_EN
          age_d        = AGE_INIT;
`endif
        end
      end
    end else if (pend_valid_q) begin
      if (open_dirs[pend_dir_q]) begin
        state_d      = ST_MOVE;
        cur_dir_d    = pend_dir_q;
        pend_valid_d = 1'b0;
      end else begin
`ifdef KEYBUF_TIMEOUT_EN
        // Expire on the step that would reach zero; the <= also guards against underflow.
        if (age_q <= AGE_ONE) begin
          pend_valid_d = 1'b0;
          age_d        = '0;
        end else begin
          age_d = age_q - AGE_ONE;
        end
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_LEFT;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_LEFT;
      prev_key_q   <= KEY_NONE;
`ifdef KEYBUF_TIMEOUT_EN
      age_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      prev_key_q   <= prev_key_d;
`ifdef KEYBUF_TIMEOUT_EN
      age_q        <= age_d;
`endif
    end
  end

  assign moving      = (state_q == ST_MOVE);
  assign keycode_out = moving ? cur_keycode : KEY_NONE;
  assign cur_dir     = cur_dir_q;
  assign pend_valid  = pend_valid_q;
  assign pend_dir    = pend_dir_q;

endmodule

// File: doc/key_dir_buffer.md
KEY_DIR_BUFFER -- requirements
Module: key_dir_buffer

Interface
REQ-001 SHALL have parameter BUF_TIMEOUT, default 16 (range 1..31), giving the number of frames a pending turn is held before it is discarded.
REQ-002 SHALL have port frame_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 SHALL have port keycode, input, 8 bits: raw keyboard code (A=8'h04, D=8'h07, S=8'h16, W=8'h1A; anything else is no key).
REQ-005 SHALL have ports leftwall, rightwall, downwall and upwall, inputs, 1 bit each: 1 = path open in that direction.
REQ-006 SHALL have port playon, input, 1 bit: game active.
REQ-007 SHALL have port keycode_out, output, 8 bits: code for the current direction, driving the movement stage's keycode input.
REQ-008 SHALL have port cur_dir, output, 2 bits: current direction (00 left, 01 right, 10 down, 11 up).
REQ-009 SHALL have port moving, output, 1 bit: a current direction is held.
REQ-010 SHALL have port pend_valid, output, 1 bit: a buffered turn is pending.
REQ-011 SHALL have port pend_dir, output, 2 bits: the pending direction.

Function
REQ-012 SHALL decode keycode to {valid, dir} and register the previous raw keycode each frame.
REQ-013 SHALL treat a key as new only when it is valid and differs from the previous raw keycode; a held key SHALL NOT re-trigger.
REQ-014 SHALL implement an FSM with states IDLE (moving=0) and MOVE (moving=1), plus a separate pending slot {pend_valid, pend_dir, age counter}.
REQ-015 SHALL, on a new key whose wall signal is 1, load cur_dir with that direction, enter MOVE and clear the pending slot, all on the same edge.
REQ-016 SHALL, on a new key whose wall signal is 0, load the pending slot with pend_valid=1, pend_dir=key direction and age=BUF_TIMEOUT, leaving cur_dir unchanged.
REQ-017 SHALL, on a new key equal to cur_dir while in MOVE, take no action and leave the pending slot untouched.
REQ-018 SHALL accept the exact reverse of cur_dir (left<->right, up<->down) per REQ-015/016 with no special casing.
REQ-019 SHALL, on a frame with no new key and pend_valid=1 whose pend_dir wall is 1, set cur_dir to pend_dir, enter MOVE and clear pend_valid.
REQ-020 SHALL otherwise decrement age while pend_valid=1, and clear pend_valid on the edge where age would reach 0.
REQ-021 SHALL give a new key priority over the pending slot in the same frame; the new key replaces or supersedes the pending turn.
REQ-022 SHALL drive keycode_out combinationally from registered state: 8'h00 in IDLE; in MOVE the A/D/S/W code for cur_dir. Latency from key to keycode_out is 1 frame.
REQ-023 SHALL keep the current direction when the current-direction wall goes to 0; stopping against a wall is the movement stage's job.
REQ-024 SHALL use an age counter of $clog2(BUF_TIMEOUT+1) bits that never underflows.

Reset
REQ-025 SHALL, when Reset=0 at a frame_clk edge, set IDLE, cur_dir=00, pend_valid=0, pend_dir=00, age=0 and previous keycode=8'h00, so that keycode_out=8'h00.
REQ-026 SHALL apply the REQ-025 values on any edge where playon=0, overriding key activity mid-operation.
REQ-027 SHALL give Reset priority over playon.

Configuration
REQ-028 SHALL, with KEYBUF_TIMEOUT_EN defined, expire the pending slot per REQ-020.
REQ-029 SHALL, without KEYBUF_TIMEOUT_EN, omit the age counter and hold a pending turn until it is taken or replaced; ports are identical in both builds.

Structure
REQ-030 SHALL place in shared package pac_pkg: the dir_t enum (DIR_LEFT=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_UP=3), the KEY_A/KEY_D/KEY_S/KEY_W constants, and the state typedef.
REQ-031 SHALL place decode logic in one sub-module key_decode (keycode to valid/dir, dir to keycode), reusable by the movement stage.

Verification
REQ-032 Bench SHALL check: Reset=0 for 2 frames with keycode=8'h07 -> keycode_out=00, moving=0, pend_valid=0.
REQ-033 Bench SHALL check: IDLE with rightwall=1 and keycode 00->07 -> next frame cur_dir=01 and keycode_out=07; key held for 10 frames -> no change.
REQ-034 Bench SHALL check: moving right with upwall=0 and keycode 1A -> pend_valid=1, pend_dir=11; upwall=1 at frame 5 -> cur_dir=11, keycode_out=1A, pend_valid=0.
REQ-035 Bench SHALL check, with KEYBUF_TIMEOUT_EN and BUF_TIMEOUT=4: pending up with upwall held 0 -> pend_valid clears after exactly 4 frames and cur_dir stays 01; without the macro -> still pending after 40 frames.
REQ-036 Bench SHALL check: pending up while a new key 04 arrives with leftwall=1 in the same frame -> cur_dir=00 and pend_valid=0.
REQ-037 Bench SHALL check: playon dropped for 1 frame mid-move with a pending turn -> all state cleared and keycode_out=00.
